// File: rtl/layer_scan_if.sv
// Handshake bundle between the layer scan controller, the layer RAM read port
// and the NeoPixel bit-stream encoder.
interface layer_scan_if;
  logic        frame_rdy_in;
  logic [5:0]  rd_addr_out;
  logic [7:0]  layer_sel_out;
  logic [23:0] rd_data_in;
  logic        bit_vld_out;
  logic        bit_data_out;
  logic        bit_rdy_in;
  logic        busy_out;
  logic        frame_done_out;

  modport master (
    input  frame_rdy_in, rd_data_in, bit_rdy_in,
    output rd_addr_out, layer_sel_out, bit_vld_out, bit_data_out,
    output busy_out, frame_done_out
  );

  modport slave (
    output frame_rdy_in, rd_data_in, bit_rdy_in,
    input  rd_addr_out, layer_sel_out, bit_vld_out, bit_data_out,
    input  busy_out, frame_done_out
  );
endinterface

// File: rtl/layer_scan_ctl.sv
// Reads 8 layers x LEDS_PER_LAYER words from the layer RAMs and streams each
// 24-bit word MSB-first to the NeoPixel encoder, followed by a latch gap.
module layer_scan_ctl #(
  parameter int LEDS_PER_LAYER = 64,
  parameter int GAP_CYCLES     = 4000
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  layer_scan_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam int               GAP_W     = $clog2(GAP_CYCLES + 1);
  localparam logic [5:0]       LAST_ADDR = 6'(LEDS_PER_LAYER - 1);
  localparam logic [2:0]       LAST_LYR  = 3'd7;
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       state;
  logic             pending;
  logic [5:0]       addr;
  logic [2:0]       layer;
  logic [4:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [23:0]      shreg;
  logic [7:0]       layer_sel;
  logic             vld;
  logic             busy;
  logic             done;
  logic             xfer;

  assign xfer               = vld & bus.bit_rdy_in;
  assign bus.rd_addr_out    = addr;
  assign bus.layer_sel_out  = layer_sel;
  assign bus.bit_vld_out    = vld;
  assign bus.bit_data_out   = shreg[23];
  assign bus.busy_out       = busy;
  assign bus.frame_done_out = done;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= S_IDLE;
      pending   <= 1'b0;
      addr      <= '0;
      layer     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      shreg     <= '0;
      layer_sel <= '0;
      vld       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      // A pulse arriving on the launch cycle wins over the clear, so it is not lost.
      if (bus.frame_rdy_in) begin
        pending <= 1'b1;
      end else if (state == S_IDLE) begin
        pending <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (pending) begin
            state     <= S_READ;
            layer     <= '0;
            addr      <= '0;
            layer_sel <= 8'h01;
            busy      <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_LOAD;
        end
        S_LOAD: begin
          shreg     <= bus.rd_data_in;
          bit_cnt   <= 5'd23;
          layer_sel <= '0;
          vld       <= 1'b1;
          state     <= S_SHIFT;
        end
        S_SHIFT: begin
          if (xfer) begin
            if (bit_cnt != 5'd0) begin
              shreg   <= {shreg[22:0], 1'b0};
              bit_cnt <= bit_cnt - 1'b1;
            end else begin
              vld <= 1'b0;
              if (layer == LAST_LYR && addr == LAST_ADDR) begin
                done    <= 1'b1;
                gap_cnt <= '0;
                state   <= S_GAP;
              end else begin
                state <= S_READ;
                if (addr == LAST_ADDR) begin
                  addr      <= '0;
                  layer     <= layer + 1'b1;
                  layer_sel <= 8'h01 << (layer + 1'b1);
                end else begin
                  addr      <= addr + 1'b1;
                  layer_sel <= 8'h01 << layer;
                end
              end
            end
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_layer_scan_ctl.sv
// Scoreboard bench for layer_scan_ctl: RAM model, random encoder back-pressure,
// frame coalescing, latch gap timing and asynchronous reset mid-frame.
module tb_layer_scan_ctl;
  localparam int LPL = 64;
  localparam int GAP = 4000;

  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  layer_scan_if bus();

  layer_scan_ctl #(.LEDS_PER_LAYER(LPL), .GAP_CYCLES(GAP)) dut (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int p_cyc = 0;
  logic const_mode = 1'b0;
  logic rand_rdy   = 1'b0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] exp_word(input int l, input int a);
    return {5'b10101, 3'(l), 2'b01, 6'(a), 8'h3C};
  endfunction

  function automatic logic [23:0] ram_word(input logic [7:0] sel, input logic [5:0] a);
    if (const_mode) return 24'hA5F00F;
    for (int i = 0; i < 8; i++)
      if (sel == (8'h01 << i)) return exp_word(i, int'(a));
    return 24'hEEEEEE;
  endfunction

  // Layer RAM model: one-cycle read latency
  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    bus.rd_data_in <= ram_word(bus.layer_sel_out, bus.rd_addr_out);
  end

  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      bus.bit_rdy_in = rand_rdy ? ($urandom_range(99) < 30) : 1'b1;
    end
  end

  // Monitor: sampled on the falling edge
  logic        prev_vld = 0, prev_rdy = 0, prev_dat = 0, prev_busy = 0;
  logic [7:0]  prev_sel = 0, last_sel = 0;
  logic [5:0]  last_addr = 0;
  logic [23:0] acc = 0;
  int nbits = 0, led_idx = 0, low_run = 0, in_gap = 0;
  int busy_rise_cyc = 0, busy_fall_cyc = 0, last_xfer_cyc = 0, fd_cyc = 0;
  int fd_cnt = 0, frames_started = 0, wrap_seen = 0;

  always @(negedge clk_in) begin
    if (!rst_n_in) begin
      prev_vld = 0; prev_rdy = 0; prev_dat = 0; prev_busy = 0; prev_sel = 0;
      nbits = 0; led_idx = 0; in_gap = 0; low_run = 0;
    end else begin
      if (bus.busy_out && !prev_busy) begin
        busy_rise_cyc = cyc; frames_started++; led_idx = 0; nbits = 0;
      end
      if (!bus.busy_out && prev_busy) busy_fall_cyc = cyc;
      if (bus.frame_done_out) begin fd_cnt++; fd_cyc = cyc; end
      if (prev_vld && !prev_rdy) begin
        chk("hold_vld", bus.bit_vld_out, 1);
        chk("hold_dat", bus.bit_data_out, prev_dat);
      end
      if (bus.bit_vld_out && !prev_vld) begin
        if (in_gap != 0) chk("led_gap", low_run, 2);
        in_gap = 0;
      end
      if (bus.bit_vld_out) low_run = 0; else low_run++;
      if (bus.layer_sel_out != 0 && prev_sel == 0) begin
        if (bus.layer_sel_out == 8'h02 && bus.rd_addr_out == 0) begin
          chk("wrap_sel", last_sel, 8'h01);
          chk("wrap_addr", last_addr, 63);
          wrap_seen++;
        end
        last_sel = bus.layer_sel_out;
        last_addr = bus.rd_addr_out;
      end
      if (bus.bit_vld_out && bus.bit_rdy_in) begin
        acc = {acc[22:0], bus.bit_data_out};
        nbits++;
        last_xfer_cyc = cyc;
        if (nbits == 24) begin
          nbits = 0;
          chk("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("led_word", acc, exp_q.pop_front());
          led_idx++;
          in_gap = (led_idx != 8 * LPL) ? 1 : 0;
        end
      end
      prev_vld = bus.bit_vld_out; prev_rdy = bus.bit_rdy_in; prev_dat = bus.bit_data_out;
      prev_busy = bus.busy_out; prev_sel = bus.layer_sel_out;
    end
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic pulse();
    @(posedge clk_in);
    #1;
    bus.frame_rdy_in = 1'b1;
    p_cyc = cyc;
    @(posedge clk_in);
    #1;
    bus.frame_rdy_in = 1'b0;
  endtask

  task automatic push_frame(input logic cmode);
    for (int l = 0; l < 8; l++)
      for (int a = 0; a < LPL; a++)
        exp_q.push_back(cmode ? 24'hA5F00F : exp_word(l, a));
  endtask

  task automatic wait_vld(input string tag);
    int t = 0;
    while (!bus.bit_vld_out && t < 50) begin tick(); t++; end
    chk(tag, cyc - p_cyc, 4);
  endtask

  task automatic wait_done(input string tag);
    int f0 = fd_cnt;
    int t = 0;
    while (fd_cnt == f0 && t < 40000) begin tick(); t++; end
    chk({tag, "_tmo"}, t < 40000, 1);
    chk({tag, "_lat"}, fd_cyc - last_xfer_cyc, 1);
  endtask

  task automatic wait_busy(input logic level, input string tag);
    int t = 0;
    while (bus.busy_out !== level && t < 40000) begin tick(); t++; end
    chk(tag, t < 40000, 1);
  endtask

  initial begin
    int fdc;
    int t;
    bus.frame_rdy_in = 1'b0;
    bus.bit_rdy_in   = 1'b1;
    repeat (3) tick();
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_vld", bus.bit_vld_out, 0);
    chk("rst_sel", bus.layer_sel_out, 8'h00);
    chk("rst_addr", bus.rd_addr_out, 0);
    chk("rst_done", bus.frame_done_out, 0);
    rst_n_in = 1'b1;
    repeat (2) tick();

    // Full pattern frame with the encoder always ready
    push_frame(1'b0);
    pulse();
    wait_vld("launch_lat1");
    chk("busy_rise1", busy_rise_cyc - p_cyc, 2);
    chk("first_bit", bus.bit_data_out, exp_word(0, 0) >> 23);
    wait_done("done1");
    chk("fd_count1", fd_cnt, 1);
    chk("sb_empty1", exp_q.size(), 0);

    // New request inside the latch gap; next frame uses constant data and back-pressure
    repeat (100) tick();
    const_mode = 1'b1;
    rand_rdy   = 1'b1;
    push_frame(1'b1);
    pulse();
    wait_busy(1'b0, "busy_fall1");
    chk("gap_len1", busy_fall_cyc - last_xfer_cyc, GAP + 1);
    wait_busy(1'b1, "busy_rise2");
    chk("gap_relaunch", busy_rise_cyc - busy_fall_cyc, 1);

    // Asynchronous reset at LED 100, bit 7
    t = 0;
    while (!(led_idx == 100 && nbits == 16) && t < 30000) begin tick(); t++; end
    chk("reach_led100", t < 30000, 1);
    fdc = fd_cnt;
    rst_n_in = 1'b0;
    #1;
    chk("arst_busy", bus.busy_out, 0);
    chk("arst_vld", bus.bit_vld_out, 0);
    chk("arst_dat", bus.bit_data_out, 0);
    chk("arst_sel", bus.layer_sel_out, 8'h00);
    chk("arst_addr", bus.rd_addr_out, 0);
    exp_q.delete();
    rand_rdy   = 1'b0;
    const_mode = 1'b0;
    repeat (2) tick();
    rst_n_in = 1'b1;
    repeat (5) tick();
    chk("arst_no_done", fd_cnt, fdc);
    chk("arst_idle", bus.busy_out, 0);

    // Restart from L0A0; extra requests mid-frame coalesce into one more frame
    push_frame(1'b0);
    pulse();
    wait_vld("launch_lat3");
    chk("restart_bit23", bus.bit_data_out, exp_word(0, 0) >> 23);
    t = 0;
    while (led_idx < 200 && t < 20000) begin tick(); t++; end
    chk("reach_led200", t < 20000, 1);
    push_frame(1'b0);
    pulse();
    repeat (50) tick();
    pulse();
    wait_done("doneA");
    chk("sb_after_A", exp_q.size(), 8 * LPL);
    wait_busy(1'b0, "busy_fallA");
    chk("gap_lenA", busy_fall_cyc - last_xfer_cyc, GAP + 1);
    wait_busy(1'b1, "busy_riseB");
    chk("b_start", busy_rise_cyc - busy_fall_cyc, 1);
    wait_done("doneB");
    wait_busy(1'b0, "busy_fallB");
    chk("gap_lenB", busy_fall_cyc - last_xfer_cyc, GAP + 1);
    repeat (50) tick();
    chk("no_third", bus.busy_out, 0);
    chk("frames", frames_started, 4);
    chk("sb_final", exp_q.size(), 0);
    chk("wraps", wrap_seen, 4);
    chk("fd_total", fd_cnt, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
